// File: rtl/sram_fifo_ctrl_1w1r.sv
// FIFO controller owning both ports of a 1W1R SRAM macro, with a 2-entry
// output prefetch buffer that hides the macro's one-cycle read latency.
module sram_fifo_ctrl_1w1r #(
  parameter int DATA_WIDTH = 120,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_sram_cnt;
  logic                  r_inflight;
  logic [1:0]            r_obuf_cnt;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_capture;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH:0]   w_sram_cnt_nxt;
  logic [1:0]            w_obuf_cnt_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_ob0_nxt;
  logic [DATA_WIDTH-1:0] w_ob1_nxt;

  assign in_ready  = !rst && (r_sram_cnt < LP_DEPTH);
  assign out_valid = !rst && (r_obuf_cnt != 2'd0);
  assign out_data  = r_ob0;
  assign count     = rst ? '0 : r_count;

  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_inflight;

  // Buffer occupancy after this cycle's pop, counting the read already in flight.
  assign w_occ   = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = !rst && (r_sram_cnt != '0) && (w_occ < 3'd2);

  assign sram_csb0  = !w_accept;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = in_data;
  assign sram_csb1  = !w_issue;
  assign sram_addr1 = r_rd_ptr;

  assign w_sram_cnt_nxt = r_sram_cnt + {{ADDR_WIDTH{1'b0}}, w_accept}
                                     - {{ADDR_WIDTH{1'b0}}, w_issue};
  assign w_obuf_cnt_nxt = r_obuf_cnt + {1'b0, w_capture} - {1'b0, w_pop};
  assign w_count_nxt    = w_sram_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_issue}
                        + {{(ADDR_WIDTH-1){1'b0}}, w_obuf_cnt_nxt};

  // Captured word lands in slot (obuf_cnt - pop); a pop shifts entry 1 to head.
  always_comb begin
    w_ob0_nxt = r_ob0;
    w_ob1_nxt = r_ob1;
    if (w_pop) begin
      w_ob0_nxt = r_ob1;
    end
    if (w_capture) begin
      if ((r_obuf_cnt - {1'b0, w_pop}) == 2'd1) begin
        w_ob1_nxt = sram_dout1;
      end else begin
        w_ob0_nxt = sram_dout1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
      r_obuf_cnt <= '0;
      r_ob0      <= '0;
      r_ob1      <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_inflight <= w_issue;
      r_sram_cnt <= w_sram_cnt_nxt;
      r_obuf_cnt <= w_obuf_cnt_nxt;
      r_ob0      <= w_ob0_nxt;
      r_ob1      <= w_ob1_nxt;
      r_count    <= w_count_nxt;
    end
  end

endmodule

// File: doc/sram_fifo_ctrl_1w1r.md
Name: sram_fifo_ctrl_1w1r

Overview:
- Single-clock FIFO controller that owns both ports of the 32x120 1W1R SRAM macro.
- Upstream: a ready/valid producer. Downstream: a ready/valid consumer.
- Drives the write port (csb0/addr0/din0) and read port (csb1/addr1), and absorbs the macro's one-cycle read latency with a 2-entry output prefetch buffer.
- Both macro clocks (clk0, clk1) tie to this block's clk at the parent level.

Parameters:
- DATA_WIDTH, 120, word width; must match the macro.
- ADDR_WIDTH, 5, SRAM address width.
- DEPTH, 32, SRAM words; must equal 1<<ADDR_WIDTH.

Ports:
- clk  input  1  single clock for the block and both macro ports.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller accepts the word this cycle.
- in_data  input  DATA_WIDTH  write data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  DATA_WIDTH  head word of the prefetch buffer.
- count  output  ADDR_WIDTH+1  total words held (SRAM + in-flight + prefetch buffer), range 0..DEPTH+2.
- sram_csb0  output  1  macro write chip select, active low.
- sram_addr0  output  ADDR_WIDTH  macro write address.
- sram_din0  output  DATA_WIDTH  macro write data.
- sram_csb1  output  1  macro read chip select, active low.
- sram_addr1  output  ADDR_WIDTH  macro read address.
- sram_dout1  input  DATA_WIDTH  macro read data.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - wr_ptr, rd_ptr, sram_cnt, inflight, obuf_cnt all go to 0.
  - out_valid=0, count=0, in_ready=0 while rst is high.
  - sram_csb0=sram_csb1=1 combinationally whenever rst=1.
  - A read in flight during reset is discarded; no data survives reset.
- Write path:
  - in_ready = !rst && (sram_cnt < DEPTH), using the registered count.
  - Accept = in_valid && in_ready. On accept, drive sram_csb0=0, sram_addr0=wr_ptr, sram_din0=in_data in the same cycle (the macro samples at posedge).
  - wr_ptr increments modulo DEPTH and wraps 31->0.
  - Outside accept cycles: sram_csb0=1, sram_addr0=wr_ptr, sram_din0=in_data.
- Read issue:
  - A read issues in cycle N when sram_cnt>0 and (obuf_cnt + inflight - pop) < 2, where pop = out_valid && out_ready.
  - On issue: sram_csb1=0, sram_addr1=rd_ptr, rd_ptr increments modulo DEPTH, inflight=1 for cycle N+1.
  - Outside issue cycles: sram_csb1=1, sram_addr1=rd_ptr.
- Read capture:
  - With inflight=1 in cycle N+1, sample sram_dout1 at the posedge ending N+1 and push it into the prefetch buffer.
  - Never sample sram_dout1 in any other cycle: it is X after posedge+hold.
- Write/read hazard:
  - sram_cnt reflects only writes accepted in earlier cycles.
  - A read never targets the address being written in the same cycle, so there is no same-address simultaneous access and no same-cycle bypass.
- Prefetch buffer:
  - 2-entry FIFO. out_valid = (obuf_cnt != 0). out_data = head entry, registered.
  - Pop and capture in the same cycle are both honoured.
- Counters:
  - sram_cnt += accept, -= issue.
  - obuf_cnt += capture, -= pop.
  - count = sram_cnt + inflight + obuf_cnt, registered.
- Latency and throughput:
  - A word accepted in cycle 0 is read-issued in cycle 1, captured at the end of cycle 2, and out_valid=1 in cycle 3.
  - Sustained throughput is 1 word/cycle in and out once primed.
- Boundaries:
  - Full (sram_cnt==DEPTH): in_ready=0 even if a read issues that cycle; it goes high the next cycle.
  - Empty: out_valid=0, no read issued, sram_csb1=1.
  - Consumer stall: at most 2 words are buffered, then reads stop and the SRAM fills to DEPTH.
  - Maximum count is DEPTH+2 = 34.

Test Plan:
- Reset with in_valid=1 -> sram_csb0=sram_csb1=1, in_ready=0, out_valid=0, count=0 during rst.
- Single write 0x0..0A5 in cycle 0, out_ready=1 -> sram_csb0=0 and sram_addr0=0 in cycle 0; sram_csb1=0 and sram_addr1=0 in cycle 1; out_valid=1 and out_data=0x0..0A5 in cycle 3; count returns to 0 after the pop.
- Stream 100 incrementing words with out_ready=1 -> output in order, 1 word/cycle after the 3-cycle fill, with both pointers wrapping 31->0 correctly.
- out_ready=0 while writing 40 words -> 34 accepted (count=34), in_ready=0 from then on; then out_ready=1 drains words 0..33 in order.
- While full (count=34), assert in_valid and out_ready for 1 cycle -> no accept that cycle, in_ready=1 the next cycle.
- Assert rst with inflight=1 and obuf_cnt=2 -> all state cleared; a post-reset write of 0x77 is the first word out.
